cmp_status_pipe: RTL and testbench

Parametrised, pipelined compare unit; successor to the fixed 16-bit signed comparator. Stage 1 subtracts and registers NZCV status flags. Stage 2 derives the six relations and an encoded condition result. Supports signed and unsigned modes per operation, a valid/ready stream handshake, and a saturating match counter. Sits between operand sources (ALU/regfile read path) and branch/condition logic.

---
 rtl/cmp_status_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_cmp_status_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_status_pipe.sv
// cmp_status_pipe: two-stage pipelined magnitude compare.
// Stage 1 forms A-B and registers the NZCV status flags. Stage 2 turns the
// flags into the six relations plus a selectable condition bit. A valid/ready
// handshake runs on both ends, and a saturating counter tallies consumed
// results whose condition held.
module cmp_status_pipe #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               is_signed,
    input  logic [2:0]         cond_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               Z,
    output logic               N,
    output logic               C,
    output logic               V,
    output logic               EQ,
    output logic               NEQ,
    output logic               GT,
    output logic               GTEQ,
    output logic               LT,
    output logic               LTEQ,
    output logic               cond_true,
    input  logic               clr_count,
    output logic [COUNT_W-1:0] match_count
);

    // Condition codes, matching the cond_sel encoding.
    localparam logic [2:0] CC_EQ    = 3'd0;
    localparam logic [2:0] CC_NEQ   = 3'd1;
    localparam logic [2:0] CC_LT    = 3'd2;
    localparam logic [2:0] CC_LTEQ  = 3'd3;
    localparam logic [2:0] CC_GT    = 3'd4;
    localparam logic [2:0] CC_GTEQ  = 3'd5;
    localparam logic [2:0] CC_TRUE  = 3'd6;
    localparam logic [2:0] CC_FALSE = 3'd7;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1 state
    // ------------------------------------------------------------------
    logic       s1_valid_reg;
    logic       s1_z_reg;
    logic       s1_n_reg;
    logic       s1_c_reg;
    logic       s1_v_reg;
    logic       s1_signed_reg;
    logic [2:0] s1_sel_reg;

    // ------------------------------------------------------------------
    // Stage 2 state (drives the outputs directly)
    // ------------------------------------------------------------------
    logic s2_valid_reg;
    logic z_reg;
    logic n_reg;
    logic c_reg;
    logic v_reg;
    logic eq_reg;
    logic neq_reg;
    logic gt_reg;
    logic gteq_reg;
    logic lt_reg;
    logic lteq_reg;
    logic cond_reg;

    logic [COUNT_W-1:0] count_reg;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic s1_load;
    logic s2_load;
    logic result_fire;

    // Stage 2 can take a new beat when it is empty or its beat is leaving.
    assign s2_load     = s1_valid_reg && (!s2_valid_reg || out_ready);
    // in_ready depends only on register state and out_ready, never on in_valid.
    assign in_ready    = !s1_valid_reg || s2_load;
    assign s1_load     = in_valid && in_ready;
    assign result_fire = s2_valid_reg && out_ready;

    // ------------------------------------------------------------------
    // Stage 1 combinational: subtract via A + ~B + 1 at WIDTH+1 bits so the
    // top bit is the carry (1 = no borrow).
    // ------------------------------------------------------------------
    logic [WIDTH:0] diff;
    logic           z_next;
    logic           n_next;
    logic           c_next;
    logic           v_next;

    assign diff   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign z_next = (diff[WIDTH-1:0] == '0);
    assign n_next = diff[WIDTH-1];
    assign c_next = diff[WIDTH];
    // Signed overflow: operands differ in sign and the result sign differs
    // from A's sign.
    assign v_next = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    // Stage 1 register: capture flags and per-beat mode on accept, empty
    // out when the beat advances and nothing replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_z_reg      <= 1'b0;
            s1_n_reg      <= 1'b0;
            s1_c_reg      <= 1'b0;
            s1_v_reg      <= 1'b0;
            s1_signed_reg <= 1'b0;
            s1_sel_reg    <= 3'd0;
        end else if (s1_load) begin
            s1_valid_reg  <= 1'b1;
            s1_z_reg      <= z_next;
            s1_n_reg      <= n_next;
            s1_c_reg      <= c_next;
            s1_v_reg      <= v_next;
            s1_signed_reg <= is_signed;
            s1_sel_reg    <= cond_sel;
        end else if (s2_load) begin
            s1_valid_reg  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: relations from the stage-1 flags.
    // ------------------------------------------------------------------
    logic       lt_next;
    logic       lteq_next;
    logic       gt_next;
    logic       gteq_next;
    logic       eq_next;
    logic       neq_next;
    logic [7:0] rel_vec;
    logic [7:0] cond_hit;
    logic       cond_next;

    // Signed less-than is N^V; unsigned less-than is a borrow (C clear).
    assign lt_next   = s1_signed_reg ? (s1_n_reg ^ s1_v_reg) : ~s1_c_reg;
    assign eq_next   = s1_z_reg;
    assign neq_next  = ~s1_z_reg;
    assign lteq_next = lt_next | s1_z_reg;
    assign gt_next   = ~lt_next & ~s1_z_reg;
    assign gteq_next = ~lt_next;

    // Relation table indexed by condition code.
    always_comb begin
        rel_vec           = 8'h00;
        rel_vec[CC_EQ]    = eq_next;
        rel_vec[CC_NEQ]   = neq_next;
        rel_vec[CC_LT]    = lt_next;
        rel_vec[CC_LTEQ]  = lteq_next;
        rel_vec[CC_GT]    = gt_next;
        rel_vec[CC_GTEQ]  = gteq_next;
        rel_vec[CC_TRUE]  = 1'b1;
        rel_vec[CC_FALSE] = 1'b0;
    end

    // One-hot select of the requested relation; exactly one code matches.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cond_sel
            assign cond_hit[gi] = (s1_sel_reg == 3'(gi)) && rel_vec[gi];
        end
    endgenerate

    assign cond_next = |cond_hit;

    // Stage 2 register: all outputs load together so they describe one beat;
    // they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            z_reg        <= 1'b0;
            n_reg        <= 1'b0;
            c_reg        <= 1'b0;
            v_reg        <= 1'b0;
            eq_reg       <= 1'b0;
            neq_reg      <= 1'b0;
            gt_reg       <= 1'b0;
            gteq_reg     <= 1'b0;
            lt_reg       <= 1'b0;
            lteq_reg     <= 1'b0;
            cond_reg     <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= 1'b1;
            z_reg        <= s1_z_reg;
            n_reg        <= s1_n_reg;
            c_reg        <= s1_c_reg;
            v_reg        <= s1_v_reg;
            eq_reg       <= eq_next;
            neq_reg      <= neq_next;
            gt_reg       <= gt_next;
            gteq_reg     <= gteq_next;
            lt_reg       <= lt_next;
            lteq_reg     <= lteq_next;
            cond_reg     <= cond_next;
        end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
        end
    end

    // Match counter: clear wins over a same-cycle increment; saturates at max.
    always_ff @(posedge clk) begin
        if (reset || clr_count) begin
            count_reg <= '0;
        end else if (result_fire && cond_reg && (count_reg != COUNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign out_valid   = s2_valid_reg;
    assign Z           = z_reg;
    assign N           = n_reg;
    assign C           = c_reg;
    assign V           = v_reg;
    assign EQ          = eq_reg;
    assign NEQ         = neq_reg;
    assign GT          = gt_reg;
    assign GTEQ        = gteq_reg;
    assign LT          = lt_reg;
    assign LTEQ        = lteq_reg;
    assign cond_true   = cond_reg;
    assign match_count = count_reg;

endmodule

// File: tb/tb_cmp_status_pipe.sv
// Bench for cmp_status_pipe (WIDTH=16, COUNT_W=8). Expected results come from
// a reference model that compares the operands as plain integers.
module tb_cmp_status_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        is_signed = 1'b0;
    logic [2:0]  cond_sel = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        Z, N, C, V, EQ, NEQ, GT, GTEQ, LT, LTEQ, cond_true;
    logic        clr_count = 1'b0;
    logic [7:0]  match_count;

    logic [10:0] obs;
    assign obs = {Z, N, C, V, EQ, NEQ, LT, LTEQ, GT, GTEQ, cond_true};

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    cmp_status_pipe #(.WIDTH(16), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .is_signed(is_signed), .cond_sel(cond_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .N(N), .C(C), .V(V),
        .EQ(EQ), .NEQ(NEQ), .GT(GT), .GTEQ(GTEQ), .LT(LT), .LTEQ(LTEQ),
        .cond_true(cond_true),
        .clr_count(clr_count), .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Reference: {Z,N,C,V,EQ,NEQ,LT,LTEQ,GT,GTEQ,cond} from integer compares.
    function automatic logic [10:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sgn, input logic [2:0] sel);
        int          sa, sb, sd;
        int unsigned ua, ub;
        logic [15:0] d;
        logic        z, n, c, v, lt, gt, ct;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        d  = a - b;
        sd = sa - sb;
        z  = (a == b);
        n  = d[15];
        c  = (ua >= ub);
        v  = (sd > 32767) || (sd < -32768);
        lt = sgn ? (sa < sb) : (ua < ub);
        gt = sgn ? (sa > sb) : (ua > ub);
        case (sel)
            3'd0: ct = z;
            3'd1: ct = !z;
            3'd2: ct = lt;
            3'd3: ct = lt || z;
            3'd4: ct = gt;
            3'd5: ct = !lt;
            3'd6: ct = 1'b1;
            default: ct = 1'b0;
        endcase
        return {z, n, c, v, z, !z, lt, lt || z, gt, !lt, ct};
    endfunction

    function automatic int sat_inc(input int cnt);
        return (cnt < 255) ? cnt + 1 : cnt;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (obs !== 11'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 000", obs); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (match_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", match_count); end
        exp_count = 0;
        $display("[reset] outputs=%h in_ready=%b count=%0d", obs, in_ready, match_count);
    endtask

    // Single isolated beats: latency of two edges and the flag/relation values.
    task automatic test_directed();
        logic [15:0] ta [5] = '{16'd5, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
        logic [15:0] tb [5] = '{16'd5, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic        ts [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  tc [5] = '{3'd3, 3'd2, 3'd4, 3'd4, 3'd4};
        logic [10:0] exp;
        for (int i = 0; i < 5; i++) begin
            exp = model(ta[i], tb[i], ts[i], tc[i]);
            A = ta[i]; B = tb[i]; is_signed = ts[i]; cond_sel = tc[i];
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
            @(posedge clk); #1 in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_latency: out_valid got %b want 1", i, out_valid); end
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, obs, exp); end
            if (exp[0]) exp_count = sat_inc(exp_count);
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_drain: out_valid got %b want 0", i, out_valid); end
            n_cmp++;
            if (match_count !== 8'(exp_count)) begin n_bad++; $display("FAIL dir%0d_count: got %0d want %0d", i, match_count, exp_count); end
            $display("[directed] a=%h b=%h s=%b sel=%0d result=%h", ta[i], tb[i], ts[i], tc[i], obs);
        end
    endtask

    // Three beats into a stalled consumer, then release.
    task automatic test_backpressure();
        logic [15:0] ba [3] = '{16'd1, 16'd3, 16'd4};
        logic [15:0] bb [3] = '{16'd2, 16'd3, 16'd1};
        logic [10:0] q[$];
        logic [10:0] exp;
        int sent = 0;
        int got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (sent < 3);
            A = ba[sent % 3]; B = bb[sent % 3]; is_signed = 1'b1; cond_sel = 3'd2;
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    n_bad++; $display("FAIL bp_in_ready c%0d: in_ready %b accepted %0d want 0/2", cyc, in_ready, sent);
                end
                n_cmp++;
                if (q.size() == 0 || out_valid !== 1'b1 || obs !== q[0]) begin
                    n_bad++; $display("FAIL bp_hold c%0d: valid %b got %h want first beat held", cyc, out_valid, obs);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(ba[sent], bb[sent], 1'b1, 3'd2));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra: unexpected beat %h", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp || cyc != 6 + got) begin
                        n_bad++; $display("FAIL bp_beat%0d: got %h at c%0d want %h at c%0d", got, obs, cyc, exp, 6 + got);
                    end
                    if (exp[0]) exp_count = sat_inc(exp_count);
                end
                $display("[backpressure] beat %0d result=%h cycle=%0d", got, obs, cyc);
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 3) begin n_bad++; $display("FAIL bp_timeout: got %0d beats want 3", got); end
        n_cmp++;
        if (match_count !== 8'(exp_count)) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", match_count, exp_count); end
    endtask

    // 300 matching beats saturate the counter; then clear collides with a match.
    task automatic test_counter();
        logic [10:0] q[$];
        logic [10:0] exp;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        exp_count = 0;
        out_ready = 1'b1; is_signed = 1'b0; cond_sel = 3'd4;
        while (got < 300 && cyc < 1000) begin
            in_valid = (sent < 300);
            B = 16'($urandom_range(0, 16'hFFFE));
            A = 16'($urandom_range(int'(B) + 1, 16'hFFFF));
            #1;
            if (in_valid && in_ready) begin q.push_back(model(A, B, 1'b0, 3'd4)); sent++; end
            if (out_valid && out_ready) begin
                n_cmp++;
                exp = (q.size() != 0) ? q.pop_front() : 11'h7FF;
                if (obs !== exp) begin n_bad++; $display("FAIL cnt_beat%0d: got %h want %h", got, obs, exp); end
                if (exp[0]) exp_count = sat_inc(exp_count);
                $display("[counter] beat %0d result=%h", got, obs);
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 300) begin n_bad++; $display("FAIL cnt_timeout: got %0d beats want 300", got); end
        n_cmp++;
        if (match_count !== 8'd255 || exp_count != 255) begin
            n_bad++; $display("FAIL cnt_saturate: got %0d want 255 (model %0d)", match_count, exp_count);
        end
        // One more matching beat; clear asserted on the cycle it is consumed.
        A = 16'd9; B = 16'd2; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
        n_cmp++;
        if (out_valid !== 1'b1 || cond_true !== 1'b1) begin
            n_bad++; $display("FAIL cnt_clr_setup: valid %b cond %b want 1/1", out_valid, cond_true);
        end
        clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        exp_count = 0;
        n_cmp++;
        if (match_count !== 8'd0) begin n_bad++; $display("FAIL cnt_clr_priority: got %0d want 0", match_count); end
        $display("[counter] clear-with-match count=%0d", match_count);
    endtask

    // Random operands, modes, stalls, gaps and occasional clears.
    task automatic test_random();
        logic [10:0] q[$];
        logic [10:0] exp;
        logic        exp_rdy;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 400 && cyc < 4000) begin
            n_cmp++;
            if (match_count !== 8'(exp_count)) begin
                n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, match_count, exp_count);
            end
            in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
            A         = 16'($urandom);
            B         = ($urandom_range(0, 3) == 0) ? A : 16'($urandom);
            is_signed = 1'($urandom);
            cond_sel  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 63) == 0);
            #1;
            // s1 is busy when more beats are in flight than s2 is showing.
            exp_rdy = ((q.size() - int'(out_valid)) == 0) || !out_valid || out_ready;
            n_cmp++;
            if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0 || obs !== q[0]) begin
                    n_bad++; $display("FAIL rnd_result c%0d: got %h want %h (queued %0d)", cyc, obs, (q.size() != 0) ? q[0] : 11'h0, q.size());
                end
            end
            if (in_valid && in_ready) begin q.push_back(model(A, B, is_signed, cond_sel)); sent++; end
            if (out_valid && out_ready && q.size() != 0) begin
                exp = q.pop_front();
                $display("[random] beat %0d result=%h", got, obs);
                got++;
                if (!clr_count && exp[0]) exp_count = sat_inc(exp_count);
            end
            if (clr_count) exp_count = 0;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; clr_count = 1'b0;
        n_cmp++;
        if (got != 400) begin n_bad++; $display("FAIL rnd_timeout: got %0d beats want 400", got); end
        n_cmp++;
        if (match_count !== 8'(exp_count)) begin n_bad++; $display("FAIL rnd_final_count: got %0d want %0d", match_count, exp_count); end
    endtask

    // Reset while both stages hold beats: nothing may emerge afterwards.
    task automatic test_reset_flush();
        out_ready = 1'b0; is_signed = 1'b1; cond_sel = 3'd6;
        A = 16'd7; B = 16'd1; in_valid = 1'b1;
        @(posedge clk); #1 A = 16'd2; B = 16'd9;
        @(posedge clk); #1 in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_count = 0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== 11'd0) begin
            n_bad++; $display("FAIL flush_outputs: valid %b outputs %h want 0/000", out_valid, obs);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || match_count !== 8'd0) begin
            n_bad++; $display("FAIL flush_state: in_ready %b count %0d want 1/0", in_ready, match_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale c%0d: out_valid %b want 0", i, out_valid); end
        end
        $display("[flush] out_valid=%b count=%0d", out_valid, match_count);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_counter();
        test_random();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
